// File: rtl/bsg_manycore_axil_mmio_pkg.sv
// Shared constants and types for the AXI-Lite MMIO slave of the host link.
package bsg_manycore_axil_mmio_pkg;

    // Register offsets, decoded from addr[7:0] only.
    localparam logic [7:0] TX_DATA_ADDR    = 8'h00;
    localparam logic [7:0] TX_CREDITS_ADDR = 8'h04;
    localparam logic [7:0] RX_DATA_ADDR    = 8'h08;
    localparam logic [7:0] RX_STATUS_ADDR  = 8'h0C;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axil_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PUSH,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

endpackage

// File: rtl/bsg_axil_aw_w_join.sv
// Latches the AW and W channels independently (either order or together) and
// holds them until the write FSM has finished with the transaction.
module bsg_axil_aw_w_join #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      accept_i,
    input  logic                      clear_i,
    input  logic [addr_width_p-1:0]   awaddr_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,
    input  logic [data_width_p-1:0]   wdata_i,
    input  logic [data_width_p/8-1:0] wstrb_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    output logic                      both_held_o,
    output logic [7:0]                addr_o,
    output logic [data_width_p-1:0]   data_o,
    output logic [data_width_p/8-1:0] strb_o
);

    logic                      aw_held_reg;
    logic                      w_held_reg;
    logic [7:0]                addr_reg;
    logic [data_width_p-1:0]   data_reg;
    logic [data_width_p/8-1:0] strb_reg;

    // Only the low byte of the address selects a register.
    logic unused_awaddr_hi;
    assign unused_awaddr_hi = ^awaddr_i[addr_width_p-1:8];

    assign awready_o   = accept_i & ~aw_held_reg;
    assign wready_o    = accept_i & ~w_held_reg;
    assign both_held_o = aw_held_reg & w_held_reg;
    assign addr_o      = addr_reg;
    assign data_o      = data_reg;
    assign strb_o      = strb_reg;

    // Capture each channel on its own handshake; release both when the response completes.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            strb_reg    <= '0;
        end else if (clear_i) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
        end else begin
            if (awvalid_i && awready_o) begin
                aw_held_reg <= 1'b1;
                addr_reg    <= awaddr_i[7:0];
            end
            if (wvalid_i && wready_o) begin
                w_held_reg <= 1'b1;
                data_reg   <= wdata_i;
                strb_reg   <= wstrb_i;
            end
        end
    end

endmodule

// File: rtl/bsg_manycore_axil_mmio_slave.sv
// AXI-Lite slave front end of the host link: TX_DATA writes become request
// words, RX_DATA reads pop response words, plus credit/status registers.
module bsg_manycore_axil_mmio_slave
    import bsg_manycore_axil_mmio_pkg::*;
#(
    parameter int axil_addr_width_p   = 32,
    parameter int axil_data_width_p   = 32,
    parameter int req_credits_width_p = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
    input  logic                           s_axil_awvalid_i,
    output logic                           s_axil_awready_o,
    input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
    input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
    input  logic                           s_axil_wvalid_i,
    output logic                           s_axil_wready_o,
    output logic [1:0]                     s_axil_bresp_o,
    output logic                           s_axil_bvalid_o,
    input  logic                           s_axil_bready_i,
    input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
    input  logic                           s_axil_arvalid_i,
    output logic                           s_axil_arready_o,
    output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
    output logic [1:0]                     s_axil_rresp_o,
    output logic                           s_axil_rvalid_o,
    input  logic                           s_axil_rready_i,
    output logic [axil_data_width_p-1:0]   axil_req_o,
    output logic                           axil_req_v_o,
    input  logic                           axil_req_ready_i,
    input  logic [axil_data_width_p-1:0]   axil_rsp_i,
    input  logic                           axil_rsp_v_i,
    output logic                           axil_rsp_ready_o,
    input  logic [req_credits_width_p-1:0] req_credits_i
);

    localparam int strb_width_lp = axil_data_width_p / 8;

    logic                         init_reg;
    wr_state_e                    wr_state_reg, wr_state_next;
    logic [1:0]                   bresp_reg, bresp_next;
    rd_state_e                    rd_state_reg, rd_state_next;
    logic [axil_data_width_p-1:0] rdata_reg, rdata_next;
    logic [1:0]                   rresp_reg, rresp_next;

    logic                         both_held;
    logic [7:0]                   wr_addr;
    logic [axil_data_width_p-1:0] wr_data;
    logic [strb_width_lp-1:0]     wr_strb;
    logic                         ar_fire;

    logic unused_araddr_hi;
    assign unused_araddr_hi = ^s_axil_araddr_i[axil_addr_width_p-1:8];

    // Hold off all address/data acceptance for one cycle after reset release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) init_reg <= 1'b0;
        else            init_reg <= 1'b1;
    end

    bsg_axil_aw_w_join #(
        .addr_width_p (axil_addr_width_p),
        .data_width_p (axil_data_width_p)
    ) aw_w_join (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .accept_i    (init_reg && (wr_state_reg == W_IDLE)),
        .clear_i     ((wr_state_reg == W_RESP) && s_axil_bready_i),
        .awaddr_i    (s_axil_awaddr_i),
        .awvalid_i   (s_axil_awvalid_i),
        .awready_o   (s_axil_awready_o),
        .wdata_i     (s_axil_wdata_i),
        .wstrb_i     (s_axil_wstrb_i),
        .wvalid_i    (s_axil_wvalid_i),
        .wready_o    (s_axil_wready_o),
        .both_held_o (both_held),
        .addr_o      (wr_addr),
        .data_o      (wr_data),
        .strb_o      (wr_strb)
    );

    // Write FSM state and the response code it decided on.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_state_reg <= W_IDLE;
            bresp_reg    <= RESP_OKAY;
        end else begin
            wr_state_reg <= wr_state_next;
            bresp_reg    <= bresp_next;
        end
    end

    // Write FSM: full-word TX_DATA writes push one request word, anything else errors.
    always_comb begin
        wr_state_next   = wr_state_reg;
        bresp_next      = bresp_reg;
        axil_req_v_o    = 1'b0;
        s_axil_bvalid_o = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                if (both_held) begin
                    if ((wr_addr == TX_DATA_ADDR) && (wr_strb == {strb_width_lp{1'b1}})) begin
                        wr_state_next = W_PUSH;
                    end else begin
                        wr_state_next = W_RESP;
                        bresp_next    = RESP_SLVERR;
                    end
                end
            end
            W_PUSH: begin
                axil_req_v_o = 1'b1;
                if (axil_req_ready_i) begin
                    wr_state_next = W_RESP;
                    bresp_next    = RESP_OKAY;
                end
            end
            W_RESP: begin
                s_axil_bvalid_o = 1'b1;
                if (s_axil_bready_i) wr_state_next = W_IDLE;
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    assign axil_req_o     = wr_data;
    assign s_axil_bresp_o = bresp_reg;

    assign s_axil_arready_o = init_reg && (rd_state_reg == R_IDLE);
    assign ar_fire          = s_axil_arvalid_i && s_axil_arready_o;

    // Read FSM state plus the read data/response captured at the AR handshake.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_state_reg <= R_IDLE;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
        end
    end

    // Read decode: the RX pop happens in the handshake cycle so a stalled rready never re-pops.
    always_comb begin
        rd_state_next    = rd_state_reg;
        rdata_next       = rdata_reg;
        rresp_next       = rresp_reg;
        s_axil_rvalid_o  = 1'b0;
        axil_rsp_ready_o = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                if (ar_fire) begin
                    rd_state_next = R_RESP;
                    rdata_next    = '0;
                    rresp_next    = RESP_OKAY;
                    case (s_axil_araddr_i[7:0])
                        TX_CREDITS_ADDR: begin
                            rdata_next = {{(axil_data_width_p-req_credits_width_p){1'b0}}, req_credits_i};
                        end
                        RX_DATA_ADDR: begin
                            if (axil_rsp_v_i) begin
                                rdata_next       = axil_rsp_i;
                                axil_rsp_ready_o = 1'b1;
                            end else begin
                                rresp_next = RESP_SLVERR;
                            end
                        end
                        RX_STATUS_ADDR: begin
                            rdata_next = {{(axil_data_width_p-1){1'b0}}, axil_rsp_v_i};
                        end
                        default: rresp_next = RESP_SLVERR;
                    endcase
                end
            end
            R_RESP: begin
                s_axil_rvalid_o = 1'b1;
                if (s_axil_rready_i) rd_state_next = R_IDLE;
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    assign s_axil_rdata_o = rdata_reg;
    assign s_axil_rresp_o = rresp_reg;

endmodule

// File: tb/tb_bsg_manycore_axil_mmio_slave.sv
// Self-checking bench: acts as AXI-Lite master and as the TX stage, and checks
// every transaction against a register-level model of the MMIO slave.
module tb_bsg_manycore_axil_mmio_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] req;
    logic        req_v;
    logic        req_ready = 1'b0;
    logic [31:0] rsp_word = '0;
    logic        rsp_v = 1'b0;
    logic        rsp_ready;
    logic [7:0]  credits = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // TX-stage model: pushed words, pending response words, credit counter.
    logic [31:0] push_log[$];
    logic [31:0] rsp_q[$];
    int n_push = 0, push_applied = 0;
    int n_pop = 0, pops_applied = 0;
    int stall_cnt = 0;
    bit rand_ready = 1'b0;
    bit stall_prev = 1'b0;
    logic [31:0] stall_word = '0;

    bsg_manycore_axil_mmio_slave dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .s_axil_awaddr_i  (awaddr),
        .s_axil_awvalid_i (awvalid),
        .s_axil_awready_o (awready),
        .s_axil_wdata_i   (wdata),
        .s_axil_wstrb_i   (wstrb),
        .s_axil_wvalid_i  (wvalid),
        .s_axil_wready_o  (wready),
        .s_axil_bresp_o   (bresp),
        .s_axil_bvalid_o  (bvalid),
        .s_axil_bready_i  (bready),
        .s_axil_araddr_i  (araddr),
        .s_axil_arvalid_i (arvalid),
        .s_axil_arready_o (arready),
        .s_axil_rdata_o   (rdata),
        .s_axil_rresp_o   (rresp),
        .s_axil_rvalid_o  (rvalid),
        .s_axil_rready_i  (rready),
        .axil_req_o       (req),
        .axil_req_v_o     (req_v),
        .axil_req_ready_i (req_ready),
        .axil_rsp_i       (rsp_word),
        .axil_rsp_v_i     (rsp_v),
        .axil_rsp_ready_o (rsp_ready),
        .req_credits_i    (credits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Observe transfers at the negedge (they complete at the following posedge).
    always @(negedge clk) begin
        if (req_v && req_ready) begin
            push_log.push_back(req);
            n_push++;
        end
        if (rsp_ready && rsp_v) n_pop++;
        if (req_v && !req_ready) begin
            if (stall_prev) chk("req_stable", req, stall_word);
            stall_prev = 1'b1;
            stall_word = req;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // TX-stage driver: apply pops/pushes just after the edge they happened on.
    always @(posedge clk) begin
        #1;
        while (pops_applied < n_pop) begin
            if (rsp_q.size() > 0) void'(rsp_q.pop_front());
            pops_applied++;
        end
        while (push_applied < n_push) begin
            credits = credits - 8'd1;
            push_applied++;
        end
        rsp_v    = (rsp_q.size() > 0);
        rsp_word = (rsp_q.size() > 0) ? rsp_q[0] : $urandom;
        if (stall_cnt > 0) begin
            req_ready = 1'b0;
            stall_cnt--;
        end else begin
            req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, exp_push;
        int cyc = 0, t = 0, push0;
        logic [1:0] exp_resp, got_resp;
        exp_push = (a == 8'h00) && (s == 4'hF);
        exp_resp = exp_push ? 2'b00 : 2'b10;
        push0 = n_push;
        @(posedge clk); #1;
        awaddr = {24'($urandom), a};
        wdata  = d;
        wstrb  = s;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            chk("b_before_aw_w", 32'(bvalid), 32'd0);
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(posedge clk); #1;
            cyc++;
            if (cyc > 100) begin
                chk("aw_w_timeout", 32'd1, 32'd0);
                break;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        @(negedge clk);
        while (!bvalid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("bvalid_seen", 32'(bvalid), 32'd1);
        repeat (b_dly) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("b_hold", 32'(bvalid), 32'd1);
        end
        @(posedge clk); #1;
        bready = 1'b1;
        @(negedge clk);
        got_resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("bresp", 32'(got_resp), 32'(exp_resp));
        chk("push_count", 32'(n_push - push0), exp_push ? 32'd1 : 32'd0);
        if (exp_push && push_log.size() > 0) chk("push_data", push_log[$], d);
        $display("WR addr=%h data=%h strb=%h bresp=%0d pushes=%0d", a, d, s, got_resp, n_push - push0);
    endtask

    task automatic axi_read(input logic [7:0] a, input int r_dly);
        int t = 0, pop0, exp_pops = 0;
        logic [31:0] exp_d, first_d, got_d;
        logic [1:0]  exp_r, got_r;
        @(posedge clk); #1;
        pop0    = n_pop;
        araddr  = {24'($urandom), a};
        arvalid = 1'b1;
        rready  = 1'b0;
        @(negedge clk);
        while (!arready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ar_handshake", 32'(arready), 32'd1);
        // Expected register value as seen by the slave at this handshake.
        exp_d = 32'd0;
        exp_r = 2'b00;
        case (a)
            8'h04: exp_d = {24'd0, credits};
            8'h08: begin
                if (rsp_q.size() > 0) begin
                    exp_d    = rsp_q[0];
                    exp_pops = 1;
                end else begin
                    exp_r = 2'b10;
                end
            end
            8'h0C: exp_d = (rsp_q.size() > 0) ? 32'd1 : 32'd0;
            default: exp_r = 2'b10;
        endcase
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        chk("ar_to_rvalid", 32'(rvalid), 32'd1);
        first_d = rdata;
        repeat (r_dly) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("r_hold", rdata, first_d);
        end
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        chk("rvalid_at_ready", 32'(rvalid), 32'd1);
        got_d = rdata;
        got_r = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        chk("rdata", got_d, exp_d);
        chk("rresp", 32'(got_r), 32'(exp_r));
        chk("pop_count", 32'(n_pop - pop0), 32'(exp_pops));
        $display("RD addr=%h rdata=%h rresp=%0d pops=%0d", a, got_d, got_r, n_pop - pop0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [7:0] wr_addrs[6];
        logic [7:0] rd_addrs[6];
        int push0;
        int t;
        wr_addrs = '{8'h00, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
        rd_addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h14, 8'h08};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_req_v", 32'(req_v), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_awready", 32'(awready), 32'd0);
        @(negedge clk);
        chk("init_awready_up", 32'(awready), 32'd1);
        chk("init_arready_up", 32'(arready), 32'd1);

        // Directed cases.
        axi_write(8'h00, 32'hA5A5_0001, 4'hF, 0, 0, 0);
        axi_write(8'h00, 32'h0BAD_0003, 4'hF, 3, 0, 1);
        stall_cnt = 11;
        axi_write(8'h00, 32'h5555_AAAA, 4'hF, 0, 0, 0);
        axi_write(8'h00, 32'h1111_2222, 4'h3, 0, 1, 0);
        axi_write(8'h04, 32'h3333_4444, 4'hF, 1, 0, 0);
        rsp_q.push_back(32'h1234_5678);
        idle(2);
        axi_read(8'h0C, 0);
        axi_read(8'h08, 5);
        axi_read(8'h08, 0);
        axi_read(8'h0C, 1);
        credits = 8'd17;
        idle(1);
        axi_read(8'h04, 0);

        // Concurrent read and write complete independently.
        credits = 8'd50;
        idle(1);
        fork
            axi_write(8'h00, 32'hC0FF_EE00, 4'hF, 0, 0, 2);
            begin idle(2); axi_read(8'h04, 1); end
        join

        // Randomized traffic.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                axi_write(wr_addrs[$urandom_range(0, 5)], $urandom,
                          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                if ($urandom_range(0, 1) == 0) rsp_q.push_back($urandom);
                if ($urandom_range(0, 2) == 0) credits = 8'($urandom);
                idle(2);
                axi_read(rd_addrs[$urandom_range(0, 5)], $urandom_range(0, 3));
            end
        end
        rand_ready = 1'b0;

        // Reset while a push is stalled: everything clears, nothing is pushed.
        stall_cnt = 1000;
        idle(2);
        push0 = n_push;
        awaddr = 32'h0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!req_v && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("push_pending", 32'(req_v), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_v", 32'(req_v), 32'd0);
        chk("mid_rst_req", req, 32'd0);
        chk("mid_rst_awready", 32'(awready), 32'd0);
        chk("mid_rst_wready", 32'(wready), 32'd0);
        chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
        chk("mid_rst_bresp", 32'(bresp), 32'd0);
        chk("mid_rst_rsp_ready", 32'(rsp_ready), 32'd0);
        stall_cnt = 0;
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_awready", 32'(awready), 32'd0);
        repeat (5) @(negedge clk);
        chk("rel_req_v", 32'(req_v), 32'd0);
        chk("rel_bvalid", 32'(bvalid), 32'd0);
        chk("rel_no_push", 32'(n_push - push0), 32'd0);
        $display("RST mid-push pushes=%0d", n_push - push0);

        axi_write(8'h00, 32'h0000_0042, 4'hF, 0, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
